// File: rtl/counter_pkg.sv
// counter_pkg: shared mode and direction encodings for the range counter family.
// Revision 1.0
`default_nettype none

package counter_pkg;

   typedef enum logic [1:0] {
      MODE_UP      = 2'd0,
      MODE_DOWN    = 2'd1,
      MODE_TRI     = 2'd2,
      MODE_ONESHOT = 2'd3
   } mode_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/range_window_cmp.sv
// range_window_cmp: combinational inclusive window compare (lo <= value <= hi).
// Revision 1.0
`default_nettype none

module range_window_cmp #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] hi_i,
   output logic             in_window_o
);

   assign in_window_o = (value_i >= lo_i) && (value_i <= hi_i);

endmodule

`default_nettype wire

// File: rtl/updown_range_counter.sv
// updown_range_counter: programmable-limit up/down/triangle/one-shot counter with window compare.
// Revision 1.0
`default_nettype none

module updown_range_counter
   import counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] win_lo,
   input  logic [WIDTH-1:0] win_hi,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             in_window,
   output logic             turn,
   output logic             done,
   output logic             cfg_err
);

   localparam logic [WIDTH-1:0] STEP = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             turn_q, turn_d;
   logic             done_q, done_d;
   mode_e            mode_q, mode_d;
   mode_e            mode_w;
   logic             cfg_err_w;
   logic             out_of_range_w;

   assign mode_w         = mode_e'(mode);
   assign cfg_err_w      = (lo > hi);
   assign out_of_range_w = (count_q < lo) || (count_q > hi);

   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      turn_d  = 1'b0;
      done_d  = done_q;
      mode_d  = mode_q;
      if (load) begin
         count_d = load_val;
         done_d  = 1'b0;
      end else if (en) begin
         // mode_q remembers the mode of the last enabled step so a switch clears done
         mode_d = mode_w;
         if (mode_w != mode_q) begin
            done_d = 1'b0;
         end
         if (cfg_err_w) begin
            count_d = lo;
            dir_d   = DIR_UP;
         end else if (out_of_range_w) begin
            if (mode_w == MODE_DOWN) begin
               count_d = hi;
               dir_d   = DIR_DOWN;
            end else begin
               count_d = lo;
               dir_d   = DIR_UP;
            end
         end else begin
            case (mode_w)
               MODE_UP: begin
                  dir_d = DIR_UP;
                  if (count_q == hi) begin
                     count_d = lo;
                     turn_d  = 1'b1;
                  end else begin
                     count_d = count_q + STEP;
                  end
               end
               MODE_DOWN: begin
                  dir_d = DIR_DOWN;
                  if (count_q == lo) begin
                     count_d = hi;
                     turn_d  = 1'b1;
                  end else begin
                     count_d = count_q - STEP;
                  end
               end
               MODE_TRI: begin
                  if (lo == hi) begin
                     dir_d  = ~dir_q;
                     turn_d = 1'b1;
                  end else if (dir_q == DIR_UP && count_q == hi) begin
                     count_d = hi - STEP;
                     dir_d   = DIR_DOWN;
                     turn_d  = 1'b1;
                  end else if (dir_q == DIR_DOWN && count_q == lo) begin
                     count_d = lo + STEP;
                     dir_d   = DIR_UP;
                     turn_d  = 1'b1;
                  end else if (dir_q == DIR_UP) begin
                     count_d = count_q + STEP;
                  end else begin
                     count_d = count_q - STEP;
                  end
               end
               default: begin
                  // One-shot: done rises exactly once, on the edge that reaches hi
                  if (count_q == hi) begin
                     if (!done_d) begin
                        done_d = 1'b1;
                        turn_d = 1'b1;
                     end
                  end else begin
                     count_d = count_q + STEP;
                     if (count_d == hi) begin
                        done_d = 1'b1;
                        turn_d = 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
         dir_q   <= DIR_UP;
         turn_q  <= 1'b0;
         done_q  <= 1'b0;
         mode_q  <= MODE_UP;
      end else begin
         count_q <= count_d;
         dir_q   <= dir_d;
         turn_q  <= turn_d;
         done_q  <= done_d;
         mode_q  <= mode_d;
      end
   end

   range_window_cmp #(
      .WIDTH(WIDTH)
   ) u_win (
      .value_i    (count_q),
      .lo_i       (win_lo),
      .hi_i       (win_hi),
      .in_window_o(in_window)
   );

   assign count   = count_q;
   assign dir     = dir_q;
   assign turn    = turn_q;
   assign done    = done_q;
   assign cfg_err = cfg_err_w;

endmodule

`default_nettype wire

// File: tb/tb_updown_range_counter.sv
// tb_updown_range_counter: directed self-checking bench for updown_range_counter.
// Revision 1.0
`default_nettype none

module tb_updown_range_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, load;
   logic [1:0] mode;
   logic [3:0] lo, hi, load_val, win_lo, win_hi;
   logic [3:0] count;
   logic       dir, in_window, turn, done, cfg_err;

   logic       en8, load8;
   logic [1:0] mode8;
   logic [7:0] lo8, hi8, load_val8, win_lo8, win_hi8;
   logic [7:0] count8;
   logic       dir8, in_window8, turn8, done8, cfg_err8;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   updown_range_counter #(.WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .lo(lo), .hi(hi),
      .load(load), .load_val(load_val), .win_lo(win_lo), .win_hi(win_hi),
      .count(count), .dir(dir), .in_window(in_window), .turn(turn),
      .done(done), .cfg_err(cfg_err)
   );

   updown_range_counter #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .en(en8), .mode(mode8), .lo(lo8), .hi(hi8),
      .load(load8), .load_val(load_val8), .win_lo(win_lo8), .win_hi(win_hi8),
      .count(count8), .dir(dir8), .in_window(in_window8), .turn(turn8),
      .done(done8), .cfg_err(cfg_err8)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      en = 1'b0; load = 1'b0; mode = 2'd0; lo = 4'd0; hi = 4'd15;
      load_val = 4'd0; win_lo = 4'd6; win_hi = 4'd9;
      en8 = 1'b0; load8 = 1'b0; mode8 = 2'd0; lo8 = 8'd0; hi8 = 8'd255;
      load_val8 = 8'd0; win_lo8 = 8'd0; win_hi8 = 8'd0;
      do_reset();
      n_checks++;
      if ({count, dir, turn, done, cfg_err} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b0})
         $display("FAIL reset_state got=%h exp=%h", {count, dir, turn, done, cfg_err}, 8'h00);
      else n_pass++;
   endtask

   task automatic test_tri_sweep();
      logic [3:0] ec;
      logic       ed, et, ew;
      int         win_cnt = 0;
      int         err = 0;
      do_reset();
      mode = 2'd2; lo = 4'd0; hi = 4'd15; win_lo = 4'd6; win_hi = 4'd9; en = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         step();
         ec = (i <= 15) ? 4'(i) : (i <= 30) ? 4'(30 - i) : 4'd1;
         ed = (i >= 16 && i <= 30);
         et = (i == 16 || i == 31);
         ew = (ec >= 4'd6 && ec <= 4'd9);
         if (i <= 30 && in_window) win_cnt++;
         if ({count, dir, turn, in_window} !== {ec, ed, et, ew}) begin
            err++;
            $display("FAIL tri_step%0d got=%h exp=%h", i, {count, dir, turn, in_window}, {ec, ed, et, ew});
         end
      end
      n_checks++;
      if (err != 0) $display("FAIL tri_sweep got=%0d_bad_steps exp=0", err);
      else n_pass++;
      n_checks++;
      if (win_cnt != 8) $display("FAIL tri_window_cycles got=%0d exp=8", win_cnt);
      else n_pass++;
   endtask

   task automatic test_up_down();
      logic [3:0] up_c [5] = '{4'd3, 4'd4, 4'd5, 4'd3, 4'd4};
      logic       up_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] dn_c [4] = '{4'd5, 4'd4, 4'd3, 4'd5};
      logic       dn_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      mode = 2'd0; lo = 4'd3; hi = 4'd5; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if ({count, dir, turn} !== {up_c[i], 1'b0, up_t[i]})
            $display("FAIL up_step%0d got=%h exp=%h", i, {count, dir, turn}, {up_c[i], 1'b0, up_t[i]});
         else n_pass++;
      end
      do_reset();
      mode = 2'd1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if ({count, dir, turn} !== {dn_c[i], 1'b1, dn_t[i]})
            $display("FAIL down_step%0d got=%h exp=%h", i, {count, dir, turn}, {dn_c[i], 1'b1, dn_t[i]});
         else n_pass++;
      end
   endtask

   task automatic test_oneshot();
      // count, turn, done after each edge; entry 5 is the load, then a restart
      logic [3:0] ec [8] = '{4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd2, 4'd3, 4'd4};
      logic       et [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       ed [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      mode = 2'd3; lo = 4'd2; hi = 4'd4; en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         load = (i == 5); load_val = 4'd2;
         step();
         n_checks++;
         if ({count, turn, done} !== {ec[i], et[i], ed[i]})
            $display("FAIL oneshot_step%0d got=%h exp=%h", i, {count, turn, done}, {ec[i], et[i], ed[i]});
         else n_pass++;
      end
      load = 1'b0;
   endtask

   task automatic test_load_priority();
      do_reset();
      mode = 2'd0; lo = 4'd2; hi = 4'd9; en = 1'b1; load = 1'b1; load_val = 4'd12;
      step();
      n_checks++;
      if ({count, turn, done} !== {4'd12, 1'b0, 1'b0})
         $display("FAIL load_value got=%h exp=%h", {count, turn, done}, {4'd12, 2'b00});
      else n_pass++;
      load = 1'b0;
      step();
      n_checks++;
      if ({count, dir, turn} !== {4'd2, 1'b0, 1'b0})
         $display("FAIL load_recover got=%h exp=%h", {count, dir, turn}, {4'd2, 2'b00});
      else n_pass++;
   endtask

   task automatic test_config_edges();
      logic edir;
      do_reset();
      mode = 2'd0; lo = 4'd7; hi = 4'd3; en = 1'b1;
      #1;
      n_checks++;
      if (cfg_err !== 1'b1) $display("FAIL cfg_err_comb got=%b exp=1", cfg_err);
      else n_pass++;
      step();
      n_checks++;
      if ({count, dir, turn} !== {4'd7, 1'b0, 1'b0})
         $display("FAIL cfg_err_count got=%h exp=%h", {count, dir, turn}, {4'd7, 2'b00});
      else n_pass++;
      mode = 2'd2; lo = 4'd5; hi = 4'd5;
      step();
      n_checks++;
      if ({count, dir, turn, cfg_err} !== {4'd5, 1'b0, 1'b0, 1'b0})
         $display("FAIL tri_eq_recover got=%h exp=%h", {count, dir, turn, cfg_err}, {4'd5, 3'b000});
      else n_pass++;
      edir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         edir = ~edir;
         n_checks++;
         if ({count, dir, turn} !== {4'd5, edir, 1'b1})
            $display("FAIL tri_eq_step%0d got=%h exp=%h", i, {count, dir, turn}, {4'd5, edir, 1'b1});
         else n_pass++;
      end
      en = 1'b0;
      mode8 = 2'd0; lo8 = 8'd250; hi8 = 8'd255; en8 = 1'b1;
      for (int i = 0; i < 6; i++) step();
      n_checks++;
      if ({count8, turn8} !== {8'd255, 1'b0})
         $display("FAIL w8_at_max got=%h exp=%h", {count8, turn8}, {8'd255, 1'b0});
      else n_pass++;
      step();
      n_checks++;
      if ({count8, dir8, turn8} !== {8'd250, 1'b0, 1'b1})
         $display("FAIL w8_wrap got=%h exp=%h", {count8, dir8, turn8}, {8'd250, 2'b01});
      else n_pass++;
      en8 = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mode = 2'd1; lo = 4'd2; hi = 4'd4; en = 1'b1;
      step();
      step();
      mode = 2'd3;
      step();
      n_checks++;
      if ({count, dir, turn, done} !== {4'd4, 1'b1, 1'b1, 1'b1})
         $display("FAIL mid_setup got=%h exp=%h", {count, dir, turn, done}, {4'd4, 3'b111});
      else n_pass++;
      do_reset();
      n_checks++;
      if ({count, dir, turn, done} !== {4'd0, 1'b0, 1'b0, 1'b0})
         $display("FAIL mid_reset got=%h exp=%h", {count, dir, turn, done}, {4'd0, 3'b000});
      else n_pass++;
   endtask

   task automatic test_hold();
      do_reset();
      mode = 2'd3; lo = 4'd0; hi = 4'd1; en = 1'b1;
      step();
      n_checks++;
      if ({count, turn, done} !== {4'd1, 1'b1, 1'b1})
         $display("FAIL hold_setup got=%h exp=%h", {count, turn, done}, {4'd1, 2'b11});
      else n_pass++;
      en = 1'b0;
      mode = 2'd0;
      step();
      step();
      n_checks++;
      if ({count, dir, turn, done} !== {4'd1, 1'b0, 1'b0, 1'b1})
         $display("FAIL hold_en0 got=%h exp=%h", {count, dir, turn, done}, {4'd1, 3'b001});
      else n_pass++;
   endtask

   initial begin
      reset = 1'b0;
      test_reset();
      test_tri_sweep();
      test_up_down();
      test_oneshot();
      test_load_priority();
      test_config_edges();
      test_reset_mid();
      test_hold();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/updown_range_counter.md
# updown_range_counter

Parametrised range counter: generalises the lab 4-bit up/down "flip" counter to any width, adds programmable limits, four count modes, load and enable, and a window-compare output. Used as a timebase and sweep generator for tick generation, PWM ramps and LED sweep effects. With WIDTH=4, mode TRI, lo=0, hi=15, window 6..9 it reproduces the legacy 0→15→0 triangle sweep and its 6..9 tick window.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- en  in  1  advance count this cycle
- mode  in  2  0 UP, 1 DOWN, 2 TRI, 3 ONESHOT
- lo  in  WIDTH  lower count limit (unsigned)
- hi  in  WIDTH  upper count limit (unsigned)
- load  in  1  synchronous load request
- load_val  in  WIDTH  value for load
- win_lo  in  WIDTH  window lower bound, inclusive
- win_hi  in  WIDTH  window upper bound, inclusive
- count  out  WIDTH  registered count
- dir  out  1  registered direction, 0 up, 1 down
- in_window  out  1  combinational, win_lo ≤ count ≤ win_hi
- turn  out  1  registered one-cycle pulse after a wrap or reversal
- done  out  1  registered, sticky ONESHOT completion
- cfg_err  out  1  combinational, lo > hi

## Operation
- Priority per cycle: reset, then load, then illegal config, then out-of-range recovery, then normal step (only when en=1).
- Reset (reset=0 at the edge): count=0, dir=0, turn=0, done=0.
- Load: count=load_val and done=0. dir is unchanged. en is ignored that cycle. No range check on load.
- cfg_err=1 on an enabled cycle: count=lo and dir=0. No turn pulse.
- Out-of-range recovery (count<lo or count>hi, en=1): UP/TRI/ONESHOT go to count=lo, dir=0; DOWN goes to count=hi, dir=1. No turn pulse.
- UP: count+1, except at hi, where count=lo and turn=1. dir is forced to 0.
- DOWN: count−1, except at lo, where count=hi and turn=1. dir is forced to 1.
- TRI: reverses direction at each limit with no dwell.
  - dir=0 at hi: count=hi−1, dir=1, turn=1.
  - dir=1 at lo: count=lo+1, dir=0, turn=1.
  - Otherwise step in the direction given by dir.
  - lo==hi: count holds, dir toggles, turn=1 every enabled cycle.
- ONESHOT: counts up from the current value.
  - At hi: count holds, done=1, turn=1 on the first arrival only.
  - done clears only on reset, load, or a mode change.
- Mode change takes effect on the next enabled cycle, starting from the current count. Entering TRI keeps dir.
- Arithmetic is modulo 2^WIDTH. The range rules guarantee the count never overflows past hi or underflows below lo. hi=2^WIDTH−1 is legal.
- en=0: count, dir and done hold; turn=0.

## Timing
- count, dir, turn and done update on the clk edge. Step latency is 1 cycle from en.
- turn is high for exactly the cycle after the wrap or reversal edge, i.e. while count shows the post-wrap value.
- in_window and cfg_err have 0-cycle latency from count and the live config inputs.
- lo, hi and win_* may change at any time. They are used as sampled on each edge.
- TRI period is 2·(hi−lo) enabled cycles. UP and DOWN periods are hi−lo+1.

## Structure
- Shared package `counter_pkg`: mode encodings MODE_UP, MODE_DOWN, MODE_TRI, MODE_ONESHOT, plus the dir constants DIR_UP/DIR_DOWN.
- Sub-module `range_window_cmp`: parametrised WIDTH, combinational inclusive window compare. It produces in_window and is reusable for other tick decoders.
- Top level: one next-state block (count, dir) with a mode case statement, plus the turn/done registers.

## Test plan
- WIDTH=4, TRI, lo=0, hi=15, win 6..9, en=1 from reset → count 0,1..15,14..0,1; turn pulses when count=14 and count=1; in_window high 4 cycles per half-period.
- UP, lo=3, hi=5, after reset → 0 recovers to 3, then 4,5,3,4; turn only with the 5→3 wrap; DOWN with the same limits → 5,4,3,5.
- ONESHOT, lo=2, hi=4, then load load_val=2 mid-hold → 2,3,4,4…; done=1 from the first 4; turn once; load clears done and the count restarts at 2.
- Load has priority over en: en=1, load=1, load_val=12, hi=9 → count=12 that cycle, then recovery to lo on the next cycle.
- Config edges: lo=7, hi=3 → cfg_err=1, count=7; TRI with lo=hi=5 → count stays 5, dir toggles each cycle, turn every cycle; WIDTH=8 UP with hi=255 → 255 wraps to lo.
- Reset mid-sweep with dir=1 and done=1 → next cycle count=0, dir=0, turn=0, done=0; en=0 holds all registers.
